// File: rtl/ds_1st_adc.sv
// First-order delta-sigma ADC back end: synchronizes and samples the external
// comparator bit, feeds it back as the 1-bit DAC, and decimates with a 3rd-order CIC.
module ds_1st_adc #(
  parameter int width     = 16,
  parameter int div_ratio = 100,
  parameter int dec_ratio = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dsm_in,
  output logic                    dsm_out,
  output logic signed [width-1:0] dout,
  output logic                    dout_valid,
  output logic                    settled
);

  localparam int L   = $clog2(dec_ratio);
  localparam int A   = 3 * L + 2;
  localparam int DW  = (div_ratio > 1) ? $clog2(div_ratio) : 1;
  localparam int SH  = 3 * L - (width - 1);
  localparam int SHR = (SH > 0) ? SH : 0;
  localparam int SHL = (SH < 0) ? -SH : 0;
  localparam int W2  = A + SHL;

  localparam logic signed [W2-1:0]    MAXV = W2'((2 ** (width - 1)) - 1);
  localparam logic signed [W2-1:0]    MINV = ~MAXV;
  localparam logic signed [width-1:0] PMAX = {1'b0, {(width - 1){1'b1}}};
  localparam logic signed [width-1:0] PMIN = {1'b1, {(width - 1){1'b0}}};

  logic [1:0]          sync;
  logic [DW-1:0]       div;
  logic                cke;
  logic [L-1:0]        dcnt;
  logic                dec_evt;
  logic                bit_q;
  logic signed [A-1:0] x;
  logic signed [A-1:0] int1, int2, int3;
  logic signed [A-1:0] d1, d2, d3;
  logic signed [A-1:0] c1, c2, c3;
  logic                v1, v2, v3;
  logic [1:0]          pcnt;
  logic signed [W2-1:0]    s;
  logic signed [width-1:0] sat;

  assign cke     = (div == DW'(div_ratio - 1));
  assign dec_evt = cke && (dcnt == L'(dec_ratio - 1));
  assign x       = bit_q ? A'(1) : '1;
  assign dsm_out = bit_q;

  // Widen before shifting so narrow-gain configurations (negative shift) scale up losslessly.
  always_comb begin
    s = W2'(c3);
    s = s <<< SHL;
    s = s >>> SHR;
    if (s > MAXV)
      sat = PMAX;
    else if (s < MINV)
      sat = PMIN;
    else
      sat = s[width-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= '0;
      div        <= '0;
      dcnt       <= '0;
      bit_q      <= 1'b0;
      int1       <= '0;
      int2       <= '0;
      int3       <= '0;
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
      c1         <= '0;
      c2         <= '0;
      c3         <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      pcnt       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      settled    <= 1'b0;
    end else begin
      sync <= {sync[0], dsm_in};
      div  <= cke ? '0 : div + 1'b1;

      if (cke) begin
        bit_q <= sync[1];
        int1  <= int1 + x;
        int2  <= int2 + int1;
        int3  <= int3 + int2;
        dcnt  <= dcnt + 1'b1;
      end

      // Comb pipeline: one stage per clk, delay registers move only with a decimated sample.
      v1 <= dec_evt;
      if (dec_evt) begin
        c1 <= int3 - d1;
        d1 <= int3;
      end
      v2 <= v1;
      if (v1) begin
        c2 <= c1 - d2;
        d2 <= c1;
      end
      v3 <= v2;
      if (v2) begin
        c3 <= c2 - d3;
        d3 <= c2;
      end

      dout_valid <= v3;
      if (v3) begin
        dout <= sat;
        if (!settled) begin
          pcnt <= pcnt + 1'b1;
          if (pcnt == 2'd2)
            settled <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ds_1st_adc.sv
// Scoreboard bench for ds_1st_adc: directed bit patterns, expected PCM values,
// pulse timing, settled behaviour and reset during the comb pipeline.
`timescale 1ns/1ps
module tb_ds_1st_adc;

  localparam int W     = 16;
  localparam int DIV   = 8;
  localparam int DEC   = 64;
  localparam int PER   = DIV * DEC;
  localparam int FIRST = DEC * DIV - 1 + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dsm_in = 1'b0;
  logic dsm_out;
  logic signed [W-1:0] dout;
  logic dout_valid;
  logic settled;

  always #5 clk = ~clk;

  ds_1st_adc #(
    .width    (W),
    .div_ratio(DIV),
    .dec_ratio(DEC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dsm_in    (dsm_in),
    .dsm_out   (dsm_out),
    .dout      (dout),
    .dout_valid(dout_valid),
    .settled   (settled)
  );

  typedef struct {
    int unsigned     at;
    logic            care;
    logic signed [W-1:0] val;
    logic            set_exp;
    logic            chk_bit;
    logic            bit_exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks = 0;
  int          failures = 0;
  logic        prev_valid = 1'b0;
  logic [3:0]  pat = 4'b0000;
  int unsigned pidx = 0;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && cyc == 0) begin
      chk("rst_dout", dout == 0, int'(dout), 0);
      chk("rst_valid", dout_valid == 1'b0, int'(dout_valid), 0);
      chk("rst_settled", settled == 1'b0, int'(settled), 0);
      chk("rst_dsm_out", dsm_out == 1'b0, int'(dsm_out), 0);
    end
    if (dout_valid) begin
      chk("pulse_pending", sb.size() != 0, int'(cyc), -1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc == e.at, int'(cyc), int'(e.at));
        chk("pulse_width", prev_valid == 1'b0, int'(prev_valid), 0);
        chk("settled", settled == e.set_exp, int'(settled), int'(e.set_exp));
        if (e.care)
          chk("dout", dout == e.val, int'(dout), int'(e.val));
        if (e.chk_bit)
          chk("dsm_out", dsm_out == e.bit_exp, int'(dsm_out), int'(e.bit_exp));
      end
    end else if (!rst && sb.size() != 0 && cyc > sb[0].at + 2) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL pulse_missing: got none by cycle %0d expected at %0d", cyc, e.at);
    end
    prev_valid = dout_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst && (cyc % DIV) == 0) begin
      dsm_in = pat[pidx];
      pidx   = (pidx + 1) % 4;
    end
  endtask

  // Called at posedge+1: rst is asserted immediately and held for three edges.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    dsm_in = pat[0];
    pidx   = 1;
  endtask

  task automatic push_run(input int n, input logic signed [W-1:0] v,
                          input logic cb, input logic bv);
    for (int k = 1; k <= n; k++) begin
      exp_t e;
      e.at      = FIRST + (k - 1) * PER;
      e.care    = (k >= 4);
      e.val     = v;
      e.set_exp = (k >= 3);
      e.chk_bit = cb && (k >= 4);
      e.bit_exp = bv;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0) begin
      step();
      t++;
      if (t > 16 * PER) begin
        $display("FAIL drain_timeout: queue still holds %0d entries", sb.size());
        $fatal(1, "bench stalled");
      end
    end
  endtask

  task automatic run_pat(input logic [3:0] p, input logic signed [W-1:0] v,
                         input logic cb, input logic bv);
    pat = p;
    do_reset();
    push_run(7, v, cb, bv);
    drain();
  endtask

  initial begin
    @(posedge clk);
    #1;
    run_pat(4'b1111,  16'sd32767,  1'b1, 1'b1);
    run_pat(4'b0000, -16'sd32768,  1'b1, 1'b0);
    run_pat(4'b0101,  16'sd0,      1'b0, 1'b0);
    run_pat(4'b0111,  16'sd16384,  1'b0, 1'b0);
    run_pat(4'b1000, -16'sd16384,  1'b0, 1'b0);

    // Reset one clk after the 4th decimation cke, with settled already high.
    pat = 4'b1111;
    do_reset();
    push_run(3, 16'sd0, 1'b0, 1'b0);
    drain();
    for (int t = 0; t < 4 * PER && cyc != FIRST - 4 + 3 * PER + 1; t++)
      step();
    do_reset();
    push_run(7, 16'sd32767, 1'b1, 1'b1);
    drain();

    repeat (5) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ds_1st_adc.md
# ds_1st_adc

First-order delta-sigma ADC back end: the receiving counterpart of the PDM DAC path. It oversamples an external comparator bit (RC integrator plus comparator on the board) at the modulator rate and returns the registered bit as the 1-bit feedback DAC drive. A 3rd-order CIC decimator then converts the bitstream into signed PCM samples with a valid strobe. It sits beside the DAC modulators in the DSP sub-top, fed by `dsm_in` and driving `dsm_out`.

## Interface
- `width`, 16: PCM output width, 8..16.
- `div_ratio`, 100: clk cycles per modulator sample; 50 MHz/100 = 500 kHz.
- `dec_ratio`, 64: CIC decimation ratio; power of two, 4..256.
- `clk` in 1: system clock, 50 MHz. Reset rst, synchronous, active-high; clock clk.
- `rst` in 1: synchronous active-high reset.
- `dsm_in` in 1: comparator output, asynchronous to clk.
- `dsm_out` out 1: feedback bit to the external integrator.
- `dout` out width: signed PCM sample, held between updates.
- `dout_valid` out 1: one-clk pulse when `dout` updates.
- `settled` out 1: high once CIC delay lines are primed.

## Operation
- Synchronizer: `dsm_in` passes through 2 clk flops before any use.
- Rate divider: counter `div` runs 0..div_ratio-1 and wraps. `cke` is high for one clk when `div`==div_ratio-1.
- Sampling: on each `cke`, `bit_q` <= synchronized input. `dsm_out` = `bit_q` (registered, no combinational path).
- Input map: x = +1 if `bit_q`=1, else -1. x is `bit_q` before the current `cke` edge.
- Integrators: 3 cascaded, registered, updated only on `cke`. int1 += x; int2 += old int1; int3 += old int2.
- Accumulator width: A = 3*log2(dec_ratio)+2 bits, two's complement. Wrap-around is intended and must not saturate.
- Decimation counter `dcnt` runs 0..dec_ratio-1 and advances on `cke`. The `cke` on which it wraps to 0 is the decimation event.
- On the decimation event, int3 is captured into the comb pipeline.
- Comb: 3 stages, each y = in - previous captured in. One stage per clk, A-bit modular arithmetic. Delay registers advance only on decimation events.
- Scale: s = comb3 >>> (3*log2(dec_ratio) - (width-1)), arithmetic shift.
- Saturate: clamp s to [-2^(width-1), 2^(width-1)-1]. Only +2^(width-1) actually clips, for an all-ones input.
- `settled`: set after the 3rd `dout_valid` pulse following reset, and stays set until reset.
- `dout` before `settled` is transient. Consumers discard it.

## Timing
- Reset: `div`, `dcnt`, sync flops, `bit_q`, all integrators, comb delays and pipeline clear to 0. `dsm_out`=0, `dout`=0, `dout_valid`=0, `settled`=0.
- `dsm_in` to `bit_q`: 2 clk sync, then captured at the next `cke`. `dsm_out` changes in the clk after that `cke`.
- Latency: `dout_valid` rises exactly 4 clk after the decimation-event `cke` (3 comb stages + 1 scale/saturate). `dout` updates in the same clk.
- Output period: exactly div_ratio*dec_ratio clk = 6400 clk at defaults, 7812.5 Hz. No jitter.
- First `cke` after reset: clk div_ratio-1 after rst deasserts (`div` starts at 0).
- Reset mid-conversion: the comb pipeline is flushed. No `dout_valid` may appear after rst, even if a decimation event was in flight. The `settled` count restarts.

## Test plan
- Constant `dsm_in`=1 with defaults: after `settled`, every `dout` = 32767 (clipped from 32768) and `dsm_out`=1.
- Constant `dsm_in`=0: after `settled`, every `dout` = -32768.
- `dsm_in` toggled every `cke` (1,0,1,0...): settled `dout` = 0, ±1 LSB allowed only before `settled`.
- Repeating pattern 1,1,1,0 per `cke`: settled `dout` = +16384. Pattern 0,0,0,1 gives -16384.
- Period check: `dout_valid` pulses are exactly 1 clk wide, spaced 6400 clk. The first pulse falls 4 clk after the 64th `cke` following reset. `settled` rises on the 3rd pulse.
- Assert rst during the comb pipeline (1 clk after a decimation `cke`): no `dout_valid` appears, all outputs return to 0, and the post-reset sequence matches the first-reset timing exactly.
